// File: rtl/pmu_aes_sequencer.sv
// Serial-command sequencer for the PMU AES core: deserializes frames, issues key loads/blocks, drains or checks results.
// Optional build macro PMU_SEQ_KEY_LOCK_EN: accept only the first KEY frame after reset.
module pmu_aes_sequencer #(
  parameter int          HEADER_WIDTH   = 32,
  parameter int          AES_DATA_WIDTH = 128,
  parameter int          AES_LATENCY    = 10,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter logic [31:0] UNLOCK_TAG     = 32'h600D_F00D
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_i,
  input  logic                      en,
  output logic [AES_DATA_WIDTH-1:0] aes_key_o,
  output logic                      aes_key_load,
  output logic [AES_DATA_WIDTH-1:0] aes_data_o,
  output logic                      aes_start,
  input  logic [AES_DATA_WIDTH-1:0] aes_result_i,
  output logic                      tdo,
  output logic                      tdo_valid,
  output logic                      busy,
  output logic                      pwr_up_en,
  output logic                      err
);

  localparam int FRAME = HEADER_WIDTH + AES_DATA_WIDTH;
  localparam int CW    = $clog2(FRAME);
  localparam int LW    = $clog2(AES_LATENCY + 1);
  localparam int DW    = $clog2(AES_DATA_WIDTH + 1);

  localparam logic [CW-1:0] LAST_BIT   = CW'(FRAME - 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(AES_LATENCY - 1);
  localparam logic [LW-1:0] LAT_CMP    = LW'(AES_LATENCY);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(AES_DATA_WIDTH);

  localparam logic [7:0] OP_KEY     = 8'h01;
  localparam logic [7:0] OP_DECRYPT = 8'h02;
  localparam logic [7:0] OP_UNLOCK  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_DECODE = 3'd2,
    S_WAIT   = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t                    state_r, state_s;
  logic [CW-1:0]             cnt_r, cnt_s;
  logic [FRAME-1:0]          frame_r, frame_s;
  logic [LW-1:0]             lat_r, lat_s;
  logic [DW-1:0]             drain_r, drain_s;
  logic [AES_DATA_WIDTH-1:0] result_r, result_s;
  logic                      unlock_op_r, unlock_op_s;
  logic                      key_valid_r, key_valid_s;
  logic [AES_DATA_WIDTH-1:0] key_s, data_s;
  logic                      key_load_s, start_s, tdo_s, tdo_valid_s, pwr_s, err_s;

  logic [7:0]                magic_s, opcode_s;
  logic [AES_DATA_WIDTH-1:0] payload_s;
  logic                      unused_reserved_s;

  assign magic_s           = frame_r[HEADER_WIDTH-1 -: 8];
  assign opcode_s          = frame_r[HEADER_WIDTH-9 -: 8];
  assign payload_s         = frame_r[FRAME-1 -: AES_DATA_WIDTH];
  assign unused_reserved_s = ^frame_r[HEADER_WIDTH-17:0];

  function automatic logic tag_match(input logic [AES_DATA_WIDTH-1:0] res);
    return res[AES_DATA_WIDTH-1 -: 32] == UNLOCK_TAG;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    frame_s     = frame_r;
    lat_s       = lat_r;
    drain_s     = drain_r;
    result_s    = result_r;
    unlock_op_s = unlock_op_r;
    key_valid_s = key_valid_r;
    key_s       = aes_key_o;
    data_s      = aes_data_o;
    key_load_s  = 1'b0;
    start_s     = 1'b0;
    tdo_s       = 1'b0;
    tdo_valid_s = 1'b0;
    pwr_s       = pwr_up_en;
    err_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (en) begin
          frame_s[0] = data_i;
          cnt_s      = CW'(1);
          state_s    = S_SHIFT;
        end else begin
          cnt_s = {CW{1'b0}};
        end
      end
      S_SHIFT: begin
        if (!en) begin
          err_s   = 1'b1;
          cnt_s   = {CW{1'b0}};
          state_s = S_IDLE;
        end else begin
          frame_s[cnt_r] = data_i;
          if (cnt_r == LAST_BIT) begin
            state_s = S_DECODE;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
      end
      S_DECODE: begin
        state_s = S_IDLE;
        if (magic_s != MAGIC) begin
          err_s = 1'b1;
        end else begin
          case (opcode_s)
            OP_KEY: begin
`ifdef PMU_SEQ_KEY_LOCK_EN
              if (key_valid_r) begin
                err_s = 1'b1;
              end else begin
                key_load_s  = 1'b1;
                key_s       = payload_s;
                key_valid_s = 1'b1;
              end
`else
              key_load_s  = 1'b1;
              key_s       = payload_s;
              key_valid_s = 1'b1;
`endif
            end
            OP_DECRYPT, OP_UNLOCK: begin
              if (key_valid_r) begin
                start_s     = 1'b1;
                data_s      = payload_s;
                unlock_op_s = (opcode_s == OP_UNLOCK);
                lat_s       = {LW{1'b0}};
                state_s     = S_WAIT;
              end else begin
                err_s = 1'b1;
              end
            end
            default: err_s = 1'b1;
          endcase
        end
      end
      S_WAIT: begin
        // UNLOCK spends one extra cycle so the tag check works on the captured result
        if (lat_r == LAT_LAST) begin
          result_s = aes_result_i;
          if (unlock_op_r) begin
            lat_s = lat_r + LW'(1);
          end else begin
            drain_s = {DW{1'b0}};
            state_s = S_DRAIN;
          end
        end else if (unlock_op_r && (lat_r == LAT_CMP)) begin
          if (tag_match(result_r)) begin
            pwr_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          state_s = S_IDLE;
        end else begin
          lat_s = lat_r + LW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_s = S_IDLE;
        end else begin
          tdo_s       = result_r[0];
          tdo_valid_s = 1'b1;
          result_s    = result_r >> 1;
          drain_s     = drain_r + DW'(1);
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= {CW{1'b0}};
      frame_r      <= {FRAME{1'b0}};
      lat_r        <= {LW{1'b0}};
      drain_r      <= {DW{1'b0}};
      result_r     <= {AES_DATA_WIDTH{1'b0}};
      unlock_op_r  <= 1'b0;
      key_valid_r  <= 1'b0;
      aes_key_o    <= {AES_DATA_WIDTH{1'b0}};
      aes_key_load <= 1'b0;
      aes_data_o   <= {AES_DATA_WIDTH{1'b0}};
      aes_start    <= 1'b0;
      tdo          <= 1'b0;
      tdo_valid    <= 1'b0;
      busy         <= 1'b0;
      pwr_up_en    <= 1'b0;
      err          <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      frame_r      <= frame_s;
      lat_r        <= lat_s;
      drain_r      <= drain_s;
      result_r     <= result_s;
      unlock_op_r  <= unlock_op_s;
      key_valid_r  <= key_valid_s;
      aes_key_o    <= key_s;
      aes_key_load <= key_load_s;
      aes_data_o   <= data_s;
      aes_start    <= start_s;
      tdo          <= tdo_s;
      tdo_valid    <= tdo_valid_s;
      busy         <= (state_s != S_IDLE);
      pwr_up_en    <= pwr_s;
      err          <= err_s;
    end
  end

endmodule

// File: tb/tb_pmu_aes_sequencer.sv
// Scoreboard bench for pmu_aes_sequencer: drivers queue expected strobes/streams with their cycle, a monitor pops and compares.
module tb_pmu_aes_sequencer;

  localparam int LAT   = 10;
  localparam int FRAME = 160;

  localparam int K_KEY   = 1;
  localparam int K_START = 2;
  localparam int K_ERR   = 3;
  localparam int K_TDO   = 4;
  localparam int K_PWR   = 5;

  localparam logic [127:0] PL_KEY   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] PL_KEY2  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] PL_DEC   = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] PL_UNL   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] RES_DEC  = 128'hDEADBEEF0123456789ABCDEFCAFEBEEF;
  localparam logic [127:0] RES_OK   = 128'h600DF00D00000000000000000000ABCD;
  localparam logic [127:0] RES_BAD  = 128'h600DF00E00000000000000000000ABCD;
  localparam logic [127:0] RES_DEC2 = 128'h55AA33CC0F0FF0F01234567800ABCDEF;

  logic         clk = 1'b0;
  logic         rst, data_i, en;
  logic [127:0] aes_key_o, aes_data_o, aes_result_i;
  logic         aes_key_load, aes_start, tdo, tdo_valid, busy, pwr_up_en, err;

  pmu_aes_sequencer dut (
    .clk(clk), .rst(rst), .data_i(data_i), .en(en),
    .aes_key_o(aes_key_o), .aes_key_load(aes_key_load),
    .aes_data_o(aes_data_o), .aes_start(aes_start),
    .aes_result_i(aes_result_i), .tdo(tdo), .tdo_valid(tdo_valid),
    .busy(busy), .pwr_up_en(pwr_up_en), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           kind;
    logic [127:0] val;
    int           at;
    int           len;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic expect_ev(input int kind, input logic [127:0] val, input int at, input int len);
    ev_t e;
    e.kind = kind; e.val = val; e.at = at; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [127:0] val, input int at, input int len);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d at=%0d len=%0d val=%h, expected no event", kind, at, len, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val || e.at != at || e.len != len) begin
        n_fail++;
        $display("FAIL event_kind%0d: got kind=%0d at=%0d len=%0d val=%h, expected kind=%0d at=%0d len=%0d val=%h",
                 e.kind, kind, at, len, val, e.kind, e.at, e.len, e.val);
      end
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them
  logic [127:0] tdo_acc   = 128'd0;
  int           tdo_len   = 0;
  int           tdo_start = 0;
  logic         pwr_prev  = 1'b0;
  always @(negedge clk) begin
    if (tdo_valid === 1'b1) begin
      if (tdo_len == 0) tdo_start = cyc;
      if (tdo_len < 128) tdo_acc[tdo_len] = tdo;
      tdo_len++;
    end else if (tdo_len > 0) begin
      check_ev(K_TDO, tdo_acc, tdo_start, tdo_len);
      tdo_acc = 128'd0;
      tdo_len = 0;
    end
    if (aes_key_load === 1'b1) check_ev(K_KEY, aes_key_o, cyc, 0);
    if (aes_start === 1'b1)    check_ev(K_START, aes_data_o, cyc, 0);
    if (err === 1'b1)          check_ev(K_ERR, 128'd0, cyc, 0);
    if (pwr_up_en === 1'b1 && !pwr_prev) check_ev(K_PWR, 128'd0, cyc, 0);
    pwr_prev = (pwr_up_en === 1'b1);
  end

  // Drives a full frame; n is the edge that samples the last bit. Leaves en low for one cycle.
  task automatic send_frame(input logic [7:0] magic, input logic [7:0] op, input logic [127:0] pl, output int n);
    logic [FRAME-1:0] f;
    f = {pl, magic, op, 16'h0000};
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      en     = 1'b1;
      data_i = f[i];
    end
    n = cyc + 1;
    @(negedge clk);
    en     = 1'b0;
    data_i = 1'b0;
  endtask

  task automatic send_aborted(input logic [127:0] pl, input int nbits);
    logic [FRAME-1:0] f;
    f = {pl, 8'hA5, 8'h01, 16'h0000};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      en     = 1'b1;
      data_i = f[i];
    end
    @(negedge clk);
    en     = 1'b0;
    data_i = 1'b0;
    expect_ev(K_ERR, 128'd0, cyc + 1, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    check("idle_within_budget", {127'd0, busy}, 128'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int           n;
  logic [127:0] mask20;

  initial begin
    rst = 1'b1; en = 1'b0; data_i = 1'b0; aes_result_i = 128'd0;
    repeat (3) @(negedge clk);
    check("reset_strobes", {121'd0, aes_key_load, aes_start, tdo, tdo_valid, busy, pwr_up_en, err}, 128'd0);
    check("reset_key", aes_key_o, 128'd0);
    check("reset_data", aes_data_o, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // DECRYPT before any key
    send_frame(8'hA5, 8'h02, PL_DEC, n);
    expect_ev(K_ERR, 128'd0, n + 1, 0);
    wait_idle();

    // Aborted frame, then a good KEY frame
    send_aborted(PL_KEY2, 100);
    wait_idle();
    send_frame(8'hA5, 8'h01, PL_KEY, n);
    expect_ev(K_KEY, PL_KEY, n + 1, 0);
    check("busy_in_decode", {127'd0, busy}, 128'd1);
    repeat (2) @(negedge clk);
    check("busy_low_n2", {127'd0, busy}, 128'd0);
    wait_idle();

    // Second KEY frame
    send_frame(8'hA5, 8'h01, PL_KEY2, n);
`ifdef PMU_SEQ_KEY_LOCK_EN
    expect_ev(K_ERR, 128'd0, n + 1, 0);
`else
    expect_ev(K_KEY, PL_KEY2, n + 1, 0);
`endif
    wait_idle();

    // DECRYPT streams the full result
    aes_result_i = RES_DEC;
    send_frame(8'hA5, 8'h02, PL_DEC, n);
    expect_ev(K_START, PL_DEC, n + 1, 0);
    expect_ev(K_TDO, RES_DEC, n + 2 + LAT, 128);
    wait_idle();

    // UNLOCK with matching tag, then with a mismatching one
    aes_result_i = RES_OK;
    send_frame(8'hA5, 8'h03, PL_UNL, n);
    expect_ev(K_START, PL_UNL, n + 1, 0);
    expect_ev(K_PWR, 128'd0, n + 2 + LAT, 0);
    wait_idle();
    check("pwr_held", {127'd0, pwr_up_en}, 128'd1);
    aes_result_i = RES_BAD;
    send_frame(8'hA5, 8'h03, PL_UNL, n);
    expect_ev(K_START, PL_UNL, n + 1, 0);
    expect_ev(K_ERR, 128'd0, n + 2 + LAT, 0);
    wait_idle();
    check("pwr_after_bad_tag", {127'd0, pwr_up_en}, 128'd1);

    // Bad magic and unknown opcode
    send_frame(8'h5A, 8'h02, PL_DEC, n);
    expect_ev(K_ERR, 128'd0, n + 1, 0);
    wait_idle();
    send_frame(8'hA5, 8'h07, PL_DEC, n);
    expect_ev(K_ERR, 128'd0, n + 1, 0);
    wait_idle();

    // Reset in the middle of DRAIN after 20 result bits
    mask20 = (128'd1 << 20) - 128'd1;
    aes_result_i = RES_DEC2;
    send_frame(8'hA5, 8'h02, PL_DEC, n);
    expect_ev(K_START, PL_DEC, n + 1, 0);
    expect_ev(K_TDO, RES_DEC2 & mask20, n + 2 + LAT, 20);
    while (cyc < n + 2 + LAT + 19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("after_reset_drain", {124'd0, tdo, tdo_valid, pwr_up_en, busy}, 128'd0);
    @(negedge clk);
    send_frame(8'hA5, 8'h02, PL_DEC, n);
    expect_ev(K_ERR, 128'd0, n + 1, 0);
    wait_idle();

    // Back-to-back KEY frames with one idle cycle between
    send_frame(8'hA5, 8'h01, PL_KEY, n);
    expect_ev(K_KEY, PL_KEY, n + 1, 0);
    send_frame(8'hA5, 8'h01, PL_KEY2, n);
`ifdef PMU_SEQ_KEY_LOCK_EN
    expect_ev(K_ERR, 128'd0, n + 1, 0);
`else
    expect_ev(K_KEY, PL_KEY2, n + 1, 0);
`endif
    wait_idle();

    repeat (5) @(negedge clk);
    check("all_expected_events_seen", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
